// File: rtl/mult_feeder.sv
// rtl/mult_feeder.sv - operand FIFO, launch sequencer and result register for the 4x4 shift-add multiplier
// Optional statistics ports (Op_Count, Fifo_Level) are enabled by defining MULT_FEEDER_STATS_EN.
module mult_feeder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               In_Valid,
    output logic               In_Ready,
    input  logic [WIDTH-1:0]   In_A,
    input  logic [WIDTH-1:0]   In_B,
    output logic [WIDTH-1:0]   Multiplicando,
    output logic [WIDTH-1:0]   Multiplicador,
    output logic               St,
    input  logic               Idle,
    input  logic               Done,
    input  logic [2*WIDTH-1:0] Produto,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic [2*WIDTH-1:0] Out_Produto
`ifdef MULT_FEEDER_STATS_EN
    ,
    output logic [15:0]          Op_Count,
    output logic [$clog2(DEPTH):0] Fifo_Level
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {SYNC, READY, START, BUSY} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, empty, push, launch, capture;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign In_Ready = !Rst && !full;
    assign push     = In_Valid && In_Ready;

    // Launch only when the output register is guaranteed free by the time Done arrives.
    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        capture  = 1'b0;
        case (state)
            SYNC:  if (Idle) state_nx = READY;
            READY: begin
                if (!empty && Idle && (!Out_Valid || Out_Ready)) begin
                    launch   = 1'b1;
                    state_nx = START;
                end
            end
            START: state_nx = BUSY;
            BUSY: begin
                if (Done) begin
                    capture  = 1'b1;
                    state_nx = READY;
                end
            end
            default: state_nx = SYNC;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_a[wr_ptr] <= In_A;
            mem_b[wr_ptr] <= In_B;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state         <= SYNC;
            St            <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            Multiplicando <= '0;
            Multiplicador <= '0;
            Out_Valid     <= 1'b0;
            Out_Produto   <= '0;
        end else begin
            state <= state_nx;
            St    <= launch;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (launch) begin
                Multiplicando <= mem_a[rd_ptr];
                Multiplicador <= mem_b[rd_ptr];
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({push, launch})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (capture) begin
                Out_Produto <= Produto;
                Out_Valid   <= 1'b1;
            end else if (Out_Valid && Out_Ready) begin
                Out_Valid <= 1'b0;
            end
        end
    end

`ifdef MULT_FEEDER_STATS_EN
    assign Fifo_Level = count;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) Op_Count <= '0;
        else if (capture) Op_Count <= Op_Count + 16'd1;
    end
`endif

endmodule
